ucsie_tx_credit_gate: RTL and testbench

Credit-gated transmit buffer that sits directly upstream of the UCIe adapter TX port, between the controller's packet stream and the adapter/PHY. It buffers {data, strb, sop, eop} beats in a FIFO. It releases one beat per available link credit and rebuilds credits from the credit-return indications sent by the far side. It also checks packet framing and flushes cleanly on link-down.

---
 rtl/ucsie_pkg.sv | 29 ++
 rtl/ucsie_sync_fifo.sv | 57 +++++
 rtl/ucsie_tx_credit_gate.sv | 174 +++++++++++++++++
 tb/tb_ucsie_tx_credit_gate.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ucsie_pkg.sv
// Shared constants for the UCIe TX credit gate: beat layout, framing state
// encoding and default credit configuration.
package ucsie_pkg;

  localparam int DEF_DATA_W       = 256;
  localparam int DEF_CREDIT_W     = 8;
  localparam int DEF_INIT_CREDITS = 32;

  // Beat layout, LSB first: eop, sop, strb[DATA_W/8], data[DATA_W]
  localparam int BEAT_EOP_OFS  = 0;
  localparam int BEAT_SOP_OFS  = 1;
  localparam int BEAT_STRB_OFS = 2;

  function automatic int beat_w(input int data_w);
    return data_w + data_w / 8 + 2;
  endfunction

  function automatic int beat_data_ofs(input int data_w);
    return BEAT_STRB_OFS + data_w / 8;
  endfunction

  localparam int DEF_BEAT_W = beat_w(DEF_DATA_W);

  typedef enum logic {
    FR_IDLE   = 1'b0,
    FR_IN_PKT = 1'b1
  } frame_state_e;

endpackage

// File: rtl/ucsie_sync_fifo.sv
// Generic single-clock FIFO with occupancy level and synchronous flush.
// A push while full is dropped; there is no pop-to-push bypass.
module ucsie_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [LW-1:0]    level_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_q + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/ucsie_tx_credit_gate.sv
// Credit-gated TX beat buffer in front of the UCIe adapter, with framing check and
// link-down flush. Define UCSIE_TXCR_WATCHDOG_EN to build the credit-starvation watchdog.
module ucsie_tx_credit_gate
  import ucsie_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int FIFO_DEPTH   = 16,
  parameter int CREDIT_W     = DEF_CREDIT_W,
  parameter int INIT_CREDITS = DEF_INIT_CREDITS,
  parameter int TIMEOUT_CYC  = 1024,
  localparam int STRB_W      = DATA_W / 8,
  localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [STRB_W-1:0]   in_strb,
  input  logic                in_sop,
  input  logic                in_eop,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [STRB_W-1:0]   out_strb,
  output logic                out_sop,
  output logic                out_eop,
  input  logic                link_ready,
  input  logic                crd_ret_valid,
  input  logic [CREDIT_W-1:0] crd_ret_cnt,
  output logic [CREDIT_W-1:0] credit_avail,
  output logic [LVL_W-1:0]    fifo_level,
  output logic                proto_err,
  output logic                credit_timeout
);

  localparam int BEAT_W   = beat_w(DATA_W);
  localparam int DATA_OFS = beat_data_ofs(DATA_W);
  localparam int CW1      = CREDIT_W + 1;
  localparam logic [CREDIT_W:0]   CRD_MAX  = {1'b0, {CREDIT_W{1'b1}}};
  localparam logic [CREDIT_W-1:0] INIT_CRD = CREDIT_W'(INIT_CREDITS);

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
      (INIT_CREDITS >= (1 << CREDIT_W)) || (TIMEOUT_CYC < 1)) begin : g_param_check
    $error("ucsie_tx_credit_gate: illegal parameter set");
  end

  function automatic logic [CREDIT_W-1:0] sat_credit(input logic [CREDIT_W:0] v);
    if (v > CRD_MAX) return CRD_MAX[CREDIT_W-1:0];
    return v[CREDIT_W-1:0];
  endfunction

  logic                active_q;
  logic                link_up;
  logic                in_hs;
  logic                out_hs;
  logic [BEAT_W-1:0]   wbeat;
  logic [BEAT_W-1:0]   head;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W:0]   crd_ret_ext;
  logic [CREDIT_W:0]   crd_sum;
  logic                crd_ovf;
  logic                proto_err_q, proto_err_d;
  logic                frame_err;
  frame_state_e        state_q, state_d;

  // Holds both handshakes low while reset is asserted, whatever link_ready does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) active_q <= 1'b0;
    else        active_q <= 1'b1;
  end

  assign link_up   = link_ready && active_q;
  assign in_ready  = link_up && !fifo_full;
  assign out_valid = link_up && !fifo_empty && (credit_q != '0);
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign wbeat     = {in_data, in_strb, in_sop, in_eop};

  ucsie_sync_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (!link_ready),
    .push_i  (in_hs),
    .pop_i   (out_hs),
    .wdata_i (wbeat),
    .rdata_o (head),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Stale storage stays hidden: fields read as zero whenever nothing is buffered.
  assign out_data = fifo_empty ? '0 : head[DATA_OFS +: DATA_W];
  assign out_strb = fifo_empty ? '0 : head[BEAT_STRB_OFS +: STRB_W];
  assign out_sop  = fifo_empty ? 1'b0 : head[BEAT_SOP_OFS];
  assign out_eop  = fifo_empty ? 1'b0 : head[BEAT_EOP_OFS];

  always_comb begin
    crd_ret_ext = crd_ret_valid ? {1'b0, crd_ret_cnt} : '0;
    crd_sum     = {1'b0, credit_q} + crd_ret_ext - CW1'(out_hs);
    crd_ovf     = link_ready && (crd_sum > CRD_MAX);
    credit_d    = link_ready ? sat_credit(crd_sum) : INIT_CRD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) credit_q <= INIT_CRD;
    else        credit_q <= credit_d;
  end

  // Input-side framing tracker; a mis-framed beat is kept and its eop still steers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FR_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    frame_err = 1'b0;
    if (!link_ready) begin
      state_d = FR_IDLE;
    end else if (in_hs) begin
      frame_err = (state_q == FR_IDLE) ? !in_sop : in_sop;
      state_d   = in_eop ? FR_IDLE : FR_IN_PKT;
    end
  end

  assign proto_err_d = proto_err_q || frame_err || crd_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) proto_err_q <= 1'b0;
    else        proto_err_q <= proto_err_d;
  end

  assign credit_avail = credit_q;
  assign proto_err    = proto_err_q;

`ifdef UCSIE_TXCR_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC);

  logic            starving;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            timeout_q, timeout_d;

  assign starving = link_ready && !fifo_empty && (credit_q == '0);

  always_comb begin
    wd_cnt_d = '0;
    if (starving) wd_cnt_d = (wd_cnt_q == WD_MAX) ? wd_cnt_q : wd_cnt_q + 1'b1;
    timeout_d = link_ready && (timeout_q || (wd_cnt_d == WD_MAX));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign credit_timeout = timeout_q;
`else
  assign credit_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ucsie_tx_credit_gate.sv
// Scoreboard bench for ucsie_tx_credit_gate: accepted beats are queued, a negedge
// monitor checks every output handshake, directed checks cover credits/framing/link.
module tb_ucsie_tx_credit_gate;

  localparam int DW    = 32;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 16;
  localparam int CW    = 8;
  localparam int INIT  = 32;
  localparam int TO    = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [SW-1:0] in_strb = '0;
  logic          in_sop = 1'b0;
  logic          in_eop = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [SW-1:0] out_strb;
  logic          out_sop;
  logic          out_eop;
  logic          link_ready = 1'b1;
  logic          crd_ret_valid = 1'b0;
  logic [CW-1:0] crd_ret_cnt = '0;
  logic [CW-1:0] credit_avail;
  logic [LW-1:0] fifo_level;
  logic          proto_err;
  logic          credit_timeout;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic          sop;
    logic          eop;
  } beat_t;

  beat_t sb_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  ucsie_tx_credit_gate #(
    .DATA_W       (DW),
    .FIFO_DEPTH   (DEPTH),
    .CREDIT_W     (CW),
    .INIT_CREDITS (INIT),
    .TIMEOUT_CYC  (TO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_strb        (in_strb),
    .in_sop         (in_sop),
    .in_eop         (in_eop),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_strb       (out_strb),
    .out_sop        (out_sop),
    .out_eop        (out_eop),
    .link_ready     (link_ready),
    .crd_ret_valid  (crd_ret_valid),
    .crd_ret_cnt    (crd_ret_cnt),
    .credit_avail   (credit_avail),
    .fifo_level     (fifo_level),
    .proto_err      (proto_err),
    .credit_timeout (credit_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops and compares on each output handshake, queues each accepted input beat.
  always @(negedge clk) begin
    beat_t exp_b;
    beat_t got_b;
    if (!rst_n || !link_ready) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        got_b = '{out_data, out_strb, out_sop, out_eop};
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: got %h with nothing expected", got_b);
        end else begin
          exp_b = sb_q.pop_front();
          if (got_b !== exp_b) begin
            n_fail++;
            $display("FAIL out_beat: got %h, expected %h", got_b, exp_b);
          end
        end
      end
      if (in_valid && in_ready) sb_q.push_back('{in_data, in_strb, in_sop, in_eop});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic sop, input logic eop);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_strb  = d[SW-1:0] ^ 4'h5;
    in_sop   = sop;
    in_eop   = eop;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #2;
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    check("send_accepted", ok, 1);
  endtask

  task automatic ret_credits(input int cnt);
    crd_ret_valid = 1'b1;
    crd_ret_cnt   = CW'(cnt);
    tick();
    crd_ret_valid = 1'b0;
    crd_ret_cnt   = '0;
  endtask

  task automatic drain(input int max_cyc);
    for (int i = 0; i < max_cyc && fifo_level != 0; i++) tick();
    check("drain_level", fifo_level, 0);
  endtask

  task automatic do_reset();
    in_valid      = 1'b0;
    out_ready     = 1'b0;
    crd_ret_valid = 1'b0;
    link_ready    = 1'b1;
    rst_n         = 1'b0;
    tick();
    tick();
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_credit", credit_avail, INIT);
    check("rst_level", fifo_level, 0);
    check("rst_proto_err", proto_err, 0);
    check("rst_timeout", credit_timeout, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sop", out_sop, 0);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #1;
    do_reset();

    // 4-beat packet straight through
    out_ready = 1'b1;
    send(32'h1000_0000, 1'b1, 1'b0);
    #1;
    check("s1_first_valid", out_valid, 1);
    check("s1_first_sop", out_sop, 1);
    send(32'h1000_0001, 1'b0, 1'b0);
    send(32'h1000_0002, 1'b0, 1'b0);
    send(32'h1000_0003, 1'b0, 1'b1);
    repeat (3) tick();
    check("s1_credit", credit_avail, 28);
    check("s1_level", fifo_level, 0);
    check("s1_proto_err", proto_err, 0);

    // burn credits down to 2, then starve with 5 single-beat packets
    for (int i = 0; i < 26; i++) send(32'h2000_0000 + i, 1'b1, 1'b1);
    repeat (3) tick();
    check("s2_credit_two", credit_avail, 2);
    for (int i = 0; i < 5; i++) send(32'h3000_0000 + i, 1'b1, 1'b1);
    repeat (3) tick();
    check("s2_credit_zero", credit_avail, 0);
    check("s2_out_valid", out_valid, 0);
    check("s2_level", fifo_level, 3);
    ret_credits(3);
    #1;
    check("s2_credit_ret", credit_avail, 3);
    repeat (4) tick();
    check("s2_drained_credit", credit_avail, 0);
    check("s2_drained_level", fifo_level, 0);

    // one beat stuck without credits
    send(32'h4000_0000, 1'b1, 1'b1);
    repeat (3) tick();
    check("wd_early", credit_timeout, 0);
    repeat (TO) tick();
    check("wd_level", fifo_level, 1);
`ifdef UCSIE_TXCR_WATCHDOG_EN
    check("wd_timeout", credit_timeout, 1);
`else
    check("wd_timeout", credit_timeout, 0);
`endif
    ret_credits(1);
    repeat (2) tick();
    check("wd_released_level", fifo_level, 0);

    // fill to full with sink stalled, then pop on full must not admit a push
    out_ready = 1'b0;
    ret_credits(20);
    #1;
    check("s3_credit", credit_avail, 20);
    for (int i = 0; i < 16; i++) send(32'h5000_0000 + i, 1'b1, 1'b1);
    #1;
    check("s3_level_full", fifo_level, 16);
    check("s3_ready_full", in_ready, 0);
    in_valid  = 1'b1;
    in_data   = 32'h5000_0010;
    in_strb   = 4'h5;
    in_sop    = 1'b1;
    in_eop    = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("s3_no_bypass_ready", in_ready, 0);
    check("s3_pop_valid", out_valid, 1);
    @(posedge clk);
    #2;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    #1;
    check("s3_level_after_pop", fifo_level, 15);
    send(32'h5000_0010, 1'b1, 1'b1);
    #1;
    check("s3_level_refill", fifo_level, 16);
    out_ready = 1'b1;
    drain(40);
    check("s3_credit_left", credit_avail, 3);

    // credit return overflowing in the same cycle as a pop
    ret_credits(251);
    #1;
    check("s4_credit_254", credit_avail, 254);
    send(32'h6000_0000, 1'b1, 1'b1);
    ret_credits(5);
    #1;
    check("s4_credit_sat", credit_avail, 255);
    check("s4_proto_err", proto_err, 1);
    check("s4_level", fifo_level, 0);

    // beat without sop while idle: flagged but still forwarded
    do_reset();
    out_ready = 1'b1;
    send(32'h7000_0000, 1'b0, 1'b1);
    #1;
    check("s5_proto_err", proto_err, 1);
    repeat (2) tick();
    check("s5_level", fifo_level, 0);
    check("s5_credit", credit_avail, 31);

    // link drop mid-packet with 6 beats buffered and 10 credits
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 22; i++) send(32'h8000_0000 + i, 1'b1, 1'b1);
    repeat (3) tick();
    out_ready = 1'b0;
    send(32'h9000_0000, 1'b1, 1'b0);
    for (int i = 1; i < 6; i++) send(32'h9000_0000 + i, 1'b0, 1'b0);
    #1;
    check("s6_level_before", fifo_level, 6);
    check("s6_credit_before", credit_avail, 10);
    link_ready    = 1'b0;
    crd_ret_valid = 1'b1;
    crd_ret_cnt   = 8'd7;
    tick();
    #1;
    check("s6_level_flushed", fifo_level, 0);
    check("s6_credit_reload", credit_avail, INIT);
    check("s6_out_valid", out_valid, 0);
    check("s6_in_ready", in_ready, 0);
    tick();
    check("s6_ret_ignored", credit_avail, INIT);
    link_ready    = 1'b1;
    crd_ret_valid = 1'b0;
    crd_ret_cnt   = '0;
    tick();
    out_ready = 1'b1;
    send(32'hA000_0000, 1'b1, 1'b0);
    send(32'hA000_0001, 1'b0, 1'b1);
    repeat (3) tick();
    check("s6_proto_err", proto_err, 0);
    check("s6_credit_after", credit_avail, INIT - 2);
    check("s6_level_after", fifo_level, 0);
    check("s6_timeout", credit_timeout, 0);

    check("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
